// File: rtl/systolic_result_writer.sv
// Streams a snapshot of the NxN systolic result matrix to memory as BW-word beats,
// row by row, with a running row-base address and a stall-safe ready handshake.
module systolic_result_writer #(
  parameter int unsigned N          = 8,
  parameter int unsigned BW         = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N*N*DATA_WIDTH-1:0]    Out,
  input  logic [ADDR_WIDTH-1:0]        base_C,
  input  logic [5:0]                   dim_col_C,
  input  logic [3:0]                   num_rows,
  output logic                         write,
  output logic [ADDR_WIDTH-1:0]        write_addr,
  output logic [BW*DATA_WIDTH-1:0]     writedata,
  input  logic                         write_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned NSEG   = N / BW;
  localparam int unsigned SEG_W  = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int unsigned ROW_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W  = $clog2(N + 1);
  localparam int unsigned BEAT_W = BW * DATA_WIDTH;

  // Row-major view of the matrix where each entry is one write beat.
  typedef logic [N-1:0][NSEG-1:0][BEAT_W-1:0] snap_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  snap_t                  snap_q, snap_d;
  logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;
  logic [5:0]             stride_q, stride_d;
  logic [CNT_W-1:0]       rows_q, rows_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic                   write_q, write_d;
  logic [ADDR_WIDTH-1:0]  write_addr_q, write_addr_d;
  logic [BEAT_W-1:0]      writedata_q, writedata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   last_seg_c;
  logic                   last_beat_c;
  logic [CNT_W-1:0]       eff_rows_c;

  assign last_seg_c  = (seg_q == SEG_W'(NSEG - 1));
  assign last_beat_c = last_seg_c && ((CNT_W'(row_q) + CNT_W'(1)) == rows_q);
  assign eff_rows_c  = ((num_rows == 4'd0) || (32'(num_rows) > N)) ? CNT_W'(N)
                                                                  : CNT_W'(num_rows);

  // Next-state, snapshot and registered-output logic.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    row_base_d   = row_base_q;
    stride_d     = stride_q;
    rows_d       = rows_q;
    row_d        = row_q;
    seg_d        = seg_q;
    write_d      = write_q;
    write_addr_d = write_addr_q;
    writedata_d  = writedata_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        write_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d      = S_WRITE;
          snap_d       = snap_t'(Out);
          row_base_d   = base_C;
          stride_d     = dim_col_C;
          rows_d       = eff_rows_c;
          row_d        = '0;
          seg_d        = '0;
          write_d      = 1'b1;
          write_addr_d = base_C;
          writedata_d  = snap_d[0][0];
          busy_d       = 1'b1;
        end
      end

      S_WRITE: begin
        if (write_ready) begin
          if (last_beat_c) begin
            state_d = S_DONE;
            write_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Row end jumps the base by the stride; otherwise step within the row.
            if (last_seg_c) begin
              seg_d        = '0;
              row_d        = row_q + ROW_W'(1);
              row_base_d   = row_base_q + ADDR_WIDTH'(stride_q);
              write_addr_d = row_base_d;
            end else begin
              seg_d        = seg_q + SEG_W'(1);
              write_addr_d = write_addr_q + ADDR_WIDTH'(BW);
            end
            writedata_d = snap_q[row_d][seg_d];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        write_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        write_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      row_base_q   <= '0;
      stride_q     <= '0;
      rows_q       <= '0;
      row_q        <= '0;
      seg_q        <= '0;
      write_q      <= 1'b0;
      write_addr_q <= '0;
      writedata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      row_base_q   <= row_base_d;
      stride_q     <= stride_d;
      rows_q       <= rows_d;
      row_q        <= row_d;
      seg_q        <= seg_d;
      write_q      <= write_d;
      write_addr_q <= write_addr_d;
      writedata_q  <= writedata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign write      = write_q;
  assign write_addr = write_addr_q;
  assign writedata  = writedata_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
